nova_io_master: RTL and testbench

- CPU-side I/O bus master that executes Nova I/O instructions (NIO, DIA/B/C, DOA/B/C, SKP) handed over by the CPU control unit.
- Translates each instruction into strobed bus cycles on the shared device bus (bs_stb/bs_we/bs_adr/data), including cycles to the CPU device at address 077.
- Returns read data and the skip decision to the control unit with a single-cycle acknowledge.
- Sits directly upstream of every bus device; it is the only driver of bs_stb, bs_we, bs_adr and the write-data lines.

---
 rtl/nova_io_master_if.sv | 30 +++
 rtl/nova_io_master.sv | 192 +++++++++++++++++++
 tb/tb_nova_io_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nova_io_master_if.sv
// Control-unit handshake and device-bus signals of the Nova I/O master.
// All vectors use Nova bit order: bit 0 is the most significant bit.
interface nova_io_master_if;
  logic         io_req;
  logic [0:15]  io_ir;
  logic [0:15]  io_acin;
  logic         io_busy;
  logic         io_ack;
  logic         io_acwe;
  logic [0:15]  io_acout;
  logic         io_skip;
  logic         io_err;
  logic         bs_stb;
  logic         bs_we;
  logic [0:7]   bs_adr;
  logic [0:15]  bs_dout;
  logic [0:15]  bs_din;

  modport master (
    input  io_req, io_ir, io_acin, bs_din,
    output io_busy, io_ack, io_acwe, io_acout, io_skip, io_err,
           bs_stb, bs_we, bs_adr, bs_dout
  );

  modport slave (
    output io_req, io_ir, io_acin, bs_din,
    input  io_busy, io_ack, io_acwe, io_acout, io_skip, io_err,
           bs_stb, bs_we, bs_adr, bs_dout
  );
endinterface

// File: rtl/nova_io_master.sv
// Nova I/O bus master: runs NIO/DIx/DOx/SKP as strobed device-bus cycles.
// Optional macro NOVA_IOM_ILLEGAL_EN: non-I/O opcodes complete with io_err, no bus cycle.
module nova_io_master #(
  parameter int unsigned RD_LAT = 1
) (
  input logic              pclk,
  input logic              prst,
  nova_io_master_if.master iom
);
  localparam int unsigned LAT_W = 3;

  typedef enum logic [2:0] {IDLE, XFER, RWAIT, CTRL, DONE} state_t;

  state_t           state_q, state_d;
  logic             accept;
  logic [2:0]       xfer_q, xfer_d;
  logic [1:0]       f_q, f_d;
  logic [5:0]       dev_q, dev_d;
  logic [0:15]      ac_q, ac_d;
  logic             ill_q, ill_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  logic             is_rd, is_wr, is_skp;
  logic [1:0]       op;
  logic             skp_hit;
  logic             unused_ir;

  logic             stb_q, stb_d, we_q, we_d;
  logic [0:7]       adr_q, adr_d;
  logic [0:15]      dout_q, dout_d, acout_q, acout_d;
  logic             busy_q, busy_d, ack_q, ack_d, acwe_q, acwe_d;
  logic             skip_q, skip_d, err_q, err_d;

  // Instruction fields are captured once on acceptance and held to completion.
  assign accept    = (state_q == IDLE) && iom.io_req;
  assign xfer_d    = accept ? iom.io_ir[5:7]   : xfer_q;
  assign f_d       = accept ? iom.io_ir[8:9]   : f_q;
  assign dev_d     = accept ? iom.io_ir[10:15] : dev_q;
  assign ac_d      = accept ? iom.io_acin      : ac_q;
  assign unused_ir = ^iom.io_ir[0:4];
`ifdef NOVA_IOM_ILLEGAL_EN
  assign ill_d     = accept ? (iom.io_ir[0:2] != 3'b011) : ill_q;
`else
  assign ill_d     = 1'b0;
`endif

  always_comb begin
    is_rd  = 1'b0;
    is_wr  = 1'b0;
    is_skp = 1'b0;
    op     = 2'b00;
    case (xfer_d)
      3'b001:  begin is_rd = 1'b1; op = 2'b01; end
      3'b011:  begin is_rd = 1'b1; op = 2'b10; end
      3'b101:  begin is_rd = 1'b1; op = 2'b11; end
      3'b010:  begin is_wr = 1'b1; op = 2'b01; end
      3'b100:  begin is_wr = 1'b1; op = 2'b10; end
      3'b110:  begin is_wr = 1'b1; op = 2'b11; end
      3'b111:  is_skp = 1'b1;
      default: op = 2'b00;
    endcase
  end

  // Flags word: bit 0 BUSY, bit 1 DONE.
  always_comb begin
    case (f_d)
      2'b00:   skp_hit = iom.bs_din[0];
      2'b01:   skp_hit = !iom.bs_din[0];
      2'b10:   skp_hit = iom.bs_din[1];
      default: skp_hit = !iom.bs_din[1];
    endcase
  end

  // Next state plus next-cycle output values (outputs are registered with the state).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acout_d = acout_q;
    skip_d  = 1'b0;
    stb_d   = 1'b0;
    we_d    = 1'b0;
    adr_d   = 8'h00;
    dout_d  = 16'h0000;
    ack_d   = 1'b0;
    acwe_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ill_d)                          state_d = DONE;
          else if (!is_rd && !is_wr && !is_skp) state_d = (f_d != 2'b00) ? CTRL : DONE;
          else                                state_d = XFER;
        end
      end
      XFER: begin
        if (is_wr) begin
          state_d = (f_d != 2'b00) ? CTRL : DONE;
        end else begin
          state_d = RWAIT;
          cnt_d   = LAT_W'(RD_LAT - 32'd1);
        end
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          if (is_rd)  acout_d = iom.bs_din;
          if (is_skp) skip_d  = skp_hit;
          state_d = (is_rd && (f_d != 2'b00)) ? CTRL : DONE;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      CTRL:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      XFER: begin
        stb_d  = 1'b1;
        we_d   = is_wr;
        adr_d  = {dev_d, op};
        dout_d = is_wr ? ac_d : 16'h0000;
      end
      CTRL: begin
        stb_d  = 1'b1;
        we_d   = 1'b1;
        adr_d  = {dev_d, 2'b00};
        dout_d = {14'b0, f_d};
      end
      DONE: begin
        ack_d  = 1'b1;
        acwe_d = is_rd && !ill_d;
        err_d  = ill_d;
      end
      default: ;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q <= IDLE;
      xfer_q  <= 3'b000;
      f_q     <= 2'b00;
      dev_q   <= 6'h00;
      ac_q    <= 16'h0000;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= 8'h00;
      dout_q  <= 16'h0000;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      acwe_q  <= 1'b0;
      acout_q <= 16'h0000;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      xfer_q  <= xfer_d;
      f_q     <= f_d;
      dev_q   <= dev_d;
      ac_q    <= ac_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      acwe_q  <= acwe_d;
      acout_q <= acout_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  assign iom.bs_stb   = stb_q;
  assign iom.bs_we    = we_q;
  assign iom.bs_adr   = adr_q;
  assign iom.bs_dout  = dout_q;
  assign iom.io_busy  = busy_q;
  assign iom.io_ack   = ack_q;
  assign iom.io_acwe  = acwe_q;
  assign iom.io_acout = acout_q;
  assign iom.io_skip  = skip_q;
  assign iom.io_err   = err_q;
endmodule

// File: tb/tb_nova_io_master.sv
// Scoreboard bench for nova_io_master: directed instructions, expected bus
// strobes and acknowledges queued at issue time and checked by a monitor.
module tb_nova_io_master;
  logic pclk = 1'b0;
  logic prst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [15:0] dev_rd = 16'h0000;

  typedef struct {
    bit          is_ack;
    int          cyc;
    logic        we;
    logic [7:0]  adr;
    logic [15:0] dout;
    logic        acwe;
    logic        chk_acout;
    logic [15:0] acout;
    logic        skip;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  nova_io_master_if bus();

  nova_io_master #(.RD_LAT(1)) dut (
    .pclk (pclk),
    .prst (prst),
    .iom  (bus)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  // Device model: read data registered on the strobe edge.
  always @(posedge pclk)
    bus.bs_din <= (bus.bs_stb && !bus.bs_we) ? dev_rd : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic exp_stb(input int c, input logic we, input logic [7:0] adr, input logic [15:0] dout);
    exp_t e;
    e = '{default: 0};
    e.cyc = c; e.we = we; e.adr = adr; e.dout = dout;
    q.push_back(e);
  endtask

  task automatic exp_ack(input int c, input logic acwe, input logic chk, input logic [15:0] acout,
                         input logic skip);
    exp_t e;
    e = '{default: 0};
    e.is_ack = 1'b1; e.cyc = c; e.acwe = acwe; e.chk_acout = chk; e.acout = acout; e.skip = skip;
    q.push_back(e);
  endtask

  task automatic start(input logic [15:0] ir, input logic [15:0] ac, output int c);
    @(posedge pclk); #1;
    bus.io_req  = 1'b1;
    bus.io_ir   = ir;
    bus.io_acin = ac;
    c = cyc;
  endtask

  // Drop the request and scramble the inputs to prove they were latched.
  task automatic drop();
    @(posedge pclk); #1;
    bus.io_req  = 1'b0;
    bus.io_ir   = 16'h0000;
    bus.io_acin = 16'hDEAD;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge pclk); #1;
      if (q.size() == 0 && !bus.io_busy) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout: %0d expected events outstanding, got busy=%b", name, q.size(), bus.io_busy);
      q.delete();
    end
    repeat (3) @(posedge pclk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_stb"},   32'(bus.bs_stb),   32'h0);
    check({name, "_we"},    32'(bus.bs_we),    32'h0);
    check({name, "_adr"},   32'(bus.bs_adr),   32'h0);
    check({name, "_dout"},  32'(bus.bs_dout),  32'h0);
    check({name, "_busy"},  32'(bus.io_busy),  32'h0);
    check({name, "_ack"},   32'(bus.io_ack),   32'h0);
    check({name, "_acwe"},  32'(bus.io_acwe),  32'h0);
    check({name, "_acout"}, 32'(bus.io_acout), 32'h0);
    check({name, "_skip"},  32'(bus.io_skip),  32'h0);
    check({name, "_err"},   32'(bus.io_err),   32'h0);
  endtask

  // Monitor: pops one expectation per strobe or acknowledge.
  always @(negedge pclk) begin
    if (prst === 1'b0) begin
      if (bus.bs_stb || bus.io_ack) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_event at cyc %0d: got stb=%b ack=%b adr=%h, expected no event",
                   cyc, bus.bs_stb, bus.io_ack, bus.bs_adr);
        end else begin
          mon_e = q.pop_front();
          check("event_kind", 32'(bus.io_ack), 32'(mon_e.is_ack));
          check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
          if (mon_e.is_ack) begin
            check("ack_stb", 32'(bus.bs_stb), 32'h0);
            check("ack_busy", 32'(bus.io_busy), 32'h1);
            check("ack_acwe", 32'(bus.io_acwe), 32'(mon_e.acwe));
            check("ack_skip", 32'(bus.io_skip), 32'(mon_e.skip));
            check("ack_err", 32'(bus.io_err), 32'h0);
            if (mon_e.chk_acout) check("ack_acout", 32'(bus.io_acout), 32'(mon_e.acout));
          end else begin
            check("stb_we", 32'(bus.bs_we), 32'(mon_e.we));
            check("stb_adr", 32'(bus.bs_adr), 32'(mon_e.adr));
            check("stb_dout", 32'(bus.bs_dout), 32'(mon_e.dout));
          end
        end
      end else begin
        check("idle_bus", 32'({bus.bs_we, bus.bs_adr, bus.bs_dout}), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.io_req  = 1'b0;
    bus.io_ir   = 16'h0000;
    bus.io_acin = 16'h0000;
    prst = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    check_zero("reset");
    prst = 1'b0;
    repeat (2) @(posedge pclk);

    // DOA 2,077 AC=1234
    start(16'h723F, 16'h1234, c);
    exp_stb(c + 1, 1'b1, 8'hFD, 16'h1234);
    exp_ack(c + 2, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("doa_077");

    // DIA dev 020, device returns 8010
    dev_rd = 16'h8010;
    start(16'h6110, 16'h0000, c);
    exp_stb(c + 1, 1'b0, 8'h41, 16'h0000);
    exp_ack(c + 3, 1'b1, 1'b1, 16'h8010, 1'b0);
    drop(); wait_idle("dia_020");

    // DOB dev 012 with S
    start(16'h644A, 16'hFFFF, c);
    exp_stb(c + 1, 1'b1, 8'h2A, 16'hFFFF);
    exp_stb(c + 2, 1'b1, 8'h28, 16'h0001);
    exp_ack(c + 3, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("dob_s");

    // SKP variants on dev 010, flags = DONE set, BUSY clear
    dev_rd = 16'h4000;
    start(16'h6788, 16'h0000, c);  // SKPDN
    exp_stb(c + 1, 1'b0, 8'h20, 16'h0000);
    exp_ack(c + 3, 1'b0, 1'b0, 16'h0, 1'b1);
    drop(); wait_idle("skpdn");
    start(16'h6708, 16'h0000, c);  // SKPBN
    exp_stb(c + 1, 1'b0, 8'h20, 16'h0000);
    exp_ack(c + 3, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("skpbn");
    start(16'h6748, 16'h0000, c);  // SKPBZ
    exp_stb(c + 1, 1'b0, 8'h20, 16'h0000);
    exp_ack(c + 3, 1'b0, 1'b0, 16'h0, 1'b1);
    drop(); wait_idle("skpbz");
    start(16'h67C8, 16'h0000, c);  // SKPDZ
    exp_stb(c + 1, 1'b0, 8'h20, 16'h0000);
    exp_ack(c + 3, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("skpdz");

    // NIO 0 and NIOC 077
    start(16'h6000, 16'h0000, c);
    exp_ack(c + 1, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("nio0");
    start(16'h60BF, 16'h0000, c);
    exp_stb(c + 1, 1'b1, 8'hFC, 16'h0002);
    exp_ack(c + 2, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("nioc_077");

    // DICP 077: read then control cycle, completes normally
    dev_rd = 16'hA5C3;
    start(16'h65FF, 16'h0000, c);
    exp_stb(c + 1, 1'b0, 8'hFF, 16'h0000);
    exp_stb(c + 3, 1'b1, 8'hFC, 16'h0003);
    exp_ack(c + 4, 1'b1, 1'b1, 16'hA5C3, 1'b0);
    drop(); wait_idle("dicp_077");

    // DOC dev 033 with io_req held through XFER and DONE: must be ignored
    start(16'h661B, 16'h0F0F, c);
    exp_stb(c + 1, 1'b1, 8'h6F, 16'h0F0F);
    exp_ack(c + 2, 1'b0, 1'b0, 16'h0, 1'b0);
    drop();
    bus.io_req = 1'b1;
    bus.io_ir  = 16'h60BF;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    bus.io_req = 1'b0;
    wait_idle("doc_busy_req");

    // Reset during RWAIT of DIB: aborted, no acknowledge
    dev_rd = 16'hBEEF;
    start(16'h6310, 16'h0000, c);
    exp_stb(c + 1, 1'b0, 8'h42, 16'h0000);
    drop();
    @(posedge pclk); #1;
    prst = 1'b1;
    @(posedge pclk); #1;
    check_zero("rst_mid");
    prst = 1'b0;
    start(16'h6000, 16'h0000, c);
    exp_ack(c + 1, 1'b0, 1'b0, 16'h0, 1'b0);
    drop(); wait_idle("nio_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
